// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC display controller.
// Optional build macro: RTC_SET_BLINK_EN (blinks the field being set).
package rtc_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } rtc_state_e;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam bcd_t       BCD_BLANK = 4'hF;

    // Active-high abcdefg, a = bit 6
    localparam logic [0:9][6:0] SEG_TABLE = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    // Non-BCD codes (including BCD_BLANK) show nothing
    function automatic logic [6:0] seg_encode(input bcd_t d);
        if (d <= 4'd9) begin
            return SEG_TABLE[d];
        end
        return SEG_BLANK;
    endfunction

endpackage

// File: rtl/rtc_display_ctrl_if.sv
// Shared 7-segment mux bus plus status strobes driven by the RTC controller.
interface rtc_display_ctrl_if;
    logic [6:0] seg;
    logic [2:0] sel_num;
    logic       dp;
    logic       led_ena;
    logic       pm;
    logic       sec_tick;

    modport master (output seg, sel_num, dp, led_ena, pm, sec_tick);
    modport slave  (input  seg, sel_num, dp, led_ena, pm, sec_tick);
endinterface

// File: rtl/rtc_time_core.sv
// BCD 24-hour time registers with one-second advance and set-mode edits.
module rtc_time_core
    import rtc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic adv,
    input  logic inc_hr,
    input  logic inc_min,
    input  logic clr_sec,
    output bcd_t h1,
    output bcd_t h0,
    output bcd_t m1,
    output bcd_t m0,
    output bcd_t s1,
    output bcd_t s0
);

    bcd_t h1_q, h0_q, m1_q, m0_q, s1_q, s0_q;
    bcd_t h1_d, h0_d, m1_d, m0_d, s1_d, s0_d;
    logic sec_wrap, min_wrap, min_step, hr_step;

    // Next-time: seconds roll into minutes, minutes into hours; edits never carry
    always_comb begin
        h1_d = h1_q;
        h0_d = h0_q;
        m1_d = m1_q;
        m0_d = m0_q;
        s1_d = s1_q;
        s0_d = s0_q;
        sec_wrap = (s1_q == 4'd5) && (s0_q == 4'd9);
        min_wrap = (m1_q == 4'd5) && (m0_q == 4'd9);
        min_step = (adv && sec_wrap) || inc_min;
        hr_step  = (adv && sec_wrap && min_wrap) || inc_hr;

        if (clr_sec) begin
            s1_d = 4'd0;
            s0_d = 4'd0;
        end else if (adv) begin
            if (s0_q == 4'd9) begin
                s0_d = 4'd0;
                s1_d = sec_wrap ? 4'd0 : 4'(s1_q + 4'd1);
            end else begin
                s0_d = 4'(s0_q + 4'd1);
            end
        end

        if (min_step) begin
            if (m0_q == 4'd9) begin
                m0_d = 4'd0;
                m1_d = min_wrap ? 4'd0 : 4'(m1_q + 4'd1);
            end else begin
                m0_d = 4'(m0_q + 4'd1);
            end
        end

        if (hr_step) begin
            if ((h1_q == 4'd2) && (h0_q == 4'd3)) begin
                h1_d = 4'd0;
                h0_d = 4'd0;
            end else if (h0_q == 4'd9) begin
                h0_d = 4'd0;
                h1_d = 4'(h1_q + 4'd1);
            end else begin
                h0_d = 4'(h0_q + 4'd1);
            end
        end
    end

    // Time registers
    always_ff @(posedge clk) begin
        if (rst) begin
            h1_q <= 4'd0;
            h0_q <= 4'd0;
            m1_q <= 4'd0;
            m0_q <= 4'd0;
            s1_q <= 4'd0;
            s0_q <= 4'd0;
        end else begin
            h1_q <= h1_d;
            h0_q <= h0_d;
            m1_q <= m1_d;
            m0_q <= m0_d;
            s1_q <= s1_d;
            s0_q <= s0_d;
        end
    end

    assign h1 = h1_q;
    assign h0 = h0_q;
    assign m1 = m1_q;
    assign m0 = m0_q;
    assign s1 = s1_q;
    assign s0 = s0_q;

endmodule

// File: rtl/rtc_display_ctrl.sv
// RTC display controller: set FSM, prescaler, digit scan and 12/24-hour display.
// Optional build macro: RTC_SET_BLINK_EN (blanks the field being set for half a second).
module rtc_display_ctrl
    import rtc_pkg::*;
#(
    parameter int unsigned CLK_DIV_SEC = 50000000,
    parameter int unsigned SCAN_DIV    = 32768,
    parameter int unsigned NUM_DIGITS  = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic fmt_12h,
    input  logic mode_pulse,
    input  logic inc_pulse,
    rtc_display_ctrl_if.master disp
);

    localparam int unsigned PRESC_W = $clog2(CLK_DIV_SEC);
    localparam int unsigned SCAN_W  = $clog2(SCAN_DIV);

    rtc_state_e           state_q, state_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [SCAN_W-1:0]    scan_q, scan_d;
    logic [2:0]           sel_q, sel_d, sel_nxt;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d, pm_q, pm_d, sec_tick_q, sec_tick_d;
    logic                 tick, adv, inc_hr, inc_min, clr_sec, presc_clr;
    logic                 pm_c, scan_wrap, blank;
    logic [4:0]           hr_bin, hr_disp;
    bcd_t                 h1, h0, m1, m0, s1, s0, disp_h1, disp_h0, digit;

    assign tick = ena && (presc_q == PRESC_W'(CLK_DIV_SEC - 1));

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // FSM next state: each mode pulse steps to the next field
    always_comb begin
        state_d = state_q;
        if (mode_pulse) begin
            case (state_q)
                RUN:     state_d = SET_HR;
                SET_HR:  state_d = SET_MIN;
                SET_MIN: state_d = (NUM_DIGITS == 4) ? RUN : SET_SEC;
                default: state_d = RUN;
            endcase
        end
    end

    // FSM outputs: a mode pulse swallows a coincident inc pulse
    always_comb begin
        adv       = 1'b0;
        inc_hr    = 1'b0;
        inc_min   = 1'b0;
        clr_sec   = 1'b0;
        presc_clr = 1'b0;
        case (state_q)
            RUN:     adv = tick;
            SET_HR:  inc_hr = inc_pulse && !mode_pulse;
            SET_MIN: begin
                inc_min   = inc_pulse && !mode_pulse;
                presc_clr = mode_pulse && (NUM_DIGITS == 4);
            end
            SET_SEC: begin
                clr_sec   = inc_pulse && !mode_pulse;
                presc_clr = mode_pulse;
            end
            default: ;
        endcase
    end

    rtc_time_core u_time (
        .clk     (clk),
        .rst     (rst),
        .adv     (adv),
        .inc_hr  (inc_hr),
        .inc_min (inc_min),
        .clr_sec (clr_sec),
        .h1      (h1),
        .h0      (h0),
        .m1      (m1),
        .m0      (m0),
        .s1      (s1),
        .s0      (s0)
    );

    // Prescaler, tick strobe and PM flag
    always_comb begin
        presc_d    = presc_q;
        sec_tick_d = tick;
        pm_d       = pm_c;
        if (presc_clr || tick) presc_d = '0;
        else if (ena)          presc_d = presc_q + PRESC_W'(1);
    end

    // Hour shown on the display; 12-hour mode blanks a leading zero
    always_comb begin
        hr_bin  = 5'(h1) * 5'd10 + 5'(h0);
        hr_disp = hr_bin;
        pm_c    = (hr_bin >= 5'd12);
        disp_h1 = h1;
        disp_h0 = h0;
        if (fmt_12h) begin
            if (hr_bin == 5'd0)       hr_disp = 5'd12;
            else if (hr_bin > 5'd12)  hr_disp = hr_bin - 5'd12;
            if (hr_disp >= 5'd10) begin
                disp_h1 = 4'd1;
                disp_h0 = 4'(hr_disp - 5'd10);
            end else begin
                disp_h1 = BCD_BLANK;
                disp_h0 = 4'(hr_disp);
            end
        end
    end

`ifdef RTC_SET_BLINK_EN
    // Blank the field being edited during the second half of each second
    always_comb begin
        blank = 1'b0;
        if (presc_q >= PRESC_W'(CLK_DIV_SEC / 2)) begin
            case (state_q)
                SET_HR:  blank = (sel_nxt <= 3'd1);
                SET_MIN: blank = (sel_nxt == 3'd2) || (sel_nxt == 3'd3);
                SET_SEC: blank = (sel_nxt >= 3'd4);
                default: blank = 1'b0;
            endcase
        end
    end
`else
    assign blank = 1'b0;
`endif

    // Scan: on wrap, advance the slot and load its segments/dp together
    always_comb begin
        scan_wrap = (scan_q == SCAN_W'(SCAN_DIV - 1));
        scan_d    = scan_wrap ? '0 : scan_q + SCAN_W'(1);
        sel_nxt   = (sel_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : sel_q + 3'd1;
        sel_d     = sel_q;
        seg_d     = seg_q;
        dp_d      = dp_q;
        case (sel_nxt)
            3'd0:    digit = disp_h1;
            3'd1:    digit = disp_h0;
            3'd2:    digit = m1;
            3'd3:    digit = m0;
            3'd4:    digit = s1;
            default: digit = s0;
        endcase
        if (scan_wrap) begin
            sel_d = sel_nxt;
            seg_d = blank ? SEG_BLANK : seg_encode(digit);
            dp_d  = !blank && ((sel_nxt == 3'd1) || (sel_nxt == 3'd3) ||
                    ((sel_nxt == 3'(NUM_DIGITS - 1)) && fmt_12h && pm_c));
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            scan_q     <= '0;
            sel_q      <= 3'd0;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b0;
            pm_q       <= 1'b0;
            sec_tick_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            scan_q     <= scan_d;
            sel_q      <= sel_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            pm_q       <= pm_d;
            sec_tick_q <= sec_tick_d;
        end
    end

    assign disp.seg      = seg_q;
    assign disp.sel_num  = sel_q;
    assign disp.dp       = dp_q;
    assign disp.pm       = pm_q;
    assign disp.sec_tick = sec_tick_q;
    assign disp.led_ena  = 1'b1;

endmodule

// File: tb/tb_rtc_display_ctrl.sv
// Scoreboard bench for rtc_display_ctrl: a 6-digit and a 4-digit instance.
module tb_rtc_display_ctrl;

    typedef struct {
        string      name;
        logic [2:0] sel;
        logic [6:0] seg;
        logic       dp;
        logic       pm;
    } exp_t;

    logic clk, rst;
    logic ena, fmt_12h, mode_pulse, inc_pulse;
    logic ena4, fmt4, mode4, inc4;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q6[$];
    exp_t q4[$];
    logic [2:0] prev6, prev4;

    rtc_display_ctrl_if bus6();
    rtc_display_ctrl_if bus4();

    rtc_display_ctrl #(.CLK_DIV_SEC(4), .SCAN_DIV(2), .NUM_DIGITS(6)) dut6 (
        .clk(clk), .rst(rst), .ena(ena), .fmt_12h(fmt_12h),
        .mode_pulse(mode_pulse), .inc_pulse(inc_pulse), .disp(bus6)
    );

    rtc_display_ctrl #(.CLK_DIV_SEC(4), .SCAN_DIV(2), .NUM_DIGITS(4)) dut4 (
        .clk(clk), .rst(rst), .ena(ena4), .fmt_12h(fmt4),
        .mode_pulse(mode4), .inc_pulse(inc4), .disp(bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic check_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected frame: hex digit string (F = blank), dp mask bit i = slot i
    task automatic push_frame(input string nm, input bit to4, input logic [23:0] digs,
                              input logic [5:0] dpm, input logic pmv);
        exp_t e;
        int   nd;
        nd = to4 ? 4 : 6;
        @(negedge clk);
        for (int i = 0; i < nd; i++) begin
            e.name = nm;
            e.sel  = 3'(i);
            e.seg  = enc(digs[23-4*i -: 4]);
            e.dp   = dpm[i];
            e.pm   = pmv;
            if (to4) q4.push_back(e);
            else     q6.push_back(e);
        end
    endtask

    task automatic drain(input string nm, input bit to4);
        int w;
        w = 0;
        while (((to4 ? q4.size() : q6.size()) != 0) && (w < 200)) begin
            @(negedge clk);
            w++;
        end
        check_eq({nm, "_drain"}, 32'(to4 ? q4.size() : q6.size()), 32'd0);
        if (to4) q4.delete();
        else     q6.delete();
    endtask

    task automatic pulse(input logic m, input logic i, input int n);
        for (int k = 0; k < n; k++) begin
            mode_pulse = m;
            inc_pulse  = i;
            @(negedge clk);
            mode_pulse = 1'b0;
            inc_pulse  = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic pulse4(input logic m, input logic i);
        mode4 = m;
        inc4  = i;
        @(negedge clk);
        mode4 = 1'b0;
        inc4  = 1'b0;
        @(negedge clk);
    endtask

    // Monitors: compare on every scan update whose slot matches the queue head
    always @(negedge clk) begin
        if (!rst && (bus6.sel_num != prev6) && (q6.size() != 0) && (q6[0].sel == bus6.sel_num)) begin
            check_eq({q6[0].name, "_seg"}, 32'(bus6.seg), 32'(q6[0].seg));
            check_eq({q6[0].name, "_dp"},  32'(bus6.dp),  32'(q6[0].dp));
            check_eq({q6[0].name, "_pm"},  32'(bus6.pm),  32'(q6[0].pm));
            void'(q6.pop_front());
        end
        prev6 <= bus6.sel_num;
    end

    always @(negedge clk) begin
        if (!rst && (bus4.sel_num != prev4) && (q4.size() != 0) && (q4[0].sel == bus4.sel_num)) begin
            check_eq({q4[0].name, "_seg"}, 32'(bus4.seg), 32'(q4[0].seg));
            check_eq({q4[0].name, "_dp"},  32'(bus4.dp),  32'(q4[0].dp));
            void'(q4.pop_front());
        end
        prev4 <= bus4.sel_num;
    end

    task automatic main6();
        int ticks;
        ticks = 0;
        ena = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (bus6.sec_tick) ticks++;
        end
        ena = 1'b0;
        check_eq("tick_count", 32'(ticks), 32'd10);
        push_frame("t10", 0, 24'h000010, 6'b001010, 1'b0);
        drain("t10", 0);

        // Set 23:59:00, then run 59 s to 23:59:59 and one more to midnight
        pulse(1, 0, 1);
        pulse(0, 1, 23);
        pulse(1, 0, 1);
        pulse(0, 1, 59);
        pulse(1, 0, 1);
        pulse(0, 1, 1);
        pulse(1, 0, 1);
        ena = 1'b1;
        repeat (236) @(negedge clk);
        ena = 1'b0;
        push_frame("t235959", 0, 24'h235959, 6'b001010, 1'b1);
        drain("t235959", 0);
        ena = 1'b1;
        repeat (4) @(negedge clk);
        ena = 1'b0;
        push_frame("rollover", 0, 24'h000000, 6'b001010, 1'b0);
        drain("rollover", 0);

        // 12-hour mapping
        fmt_12h = 1'b1;
        push_frame("h12_mid", 0, 24'h120000, 6'b001010, 1'b0);
        drain("h12_mid", 0);
        pulse(1, 0, 1);
        pulse(0, 1, 13);
        pulse(1, 0, 3);
        push_frame("h12_13", 0, 24'hF10000, 6'b101010, 1'b1);
        drain("h12_13", 0);
        fmt_12h = 1'b0;
        push_frame("h24_13", 0, 24'h130000, 6'b001010, 1'b1);
        drain("h24_13", 0);

        // Hour wraps 23->00; mode beats inc; minute wraps without carry
        pulse(1, 0, 1);
        pulse(0, 1, 12);
        push_frame("hr_wrap", 0, 24'h010000, 6'b001010, 1'b0);
        drain("hr_wrap", 0);
        pulse(1, 1, 1);
        pulse(0, 1, 1);
        push_frame("mode_wins", 0, 24'h010100, 6'b001010, 1'b0);
        drain("mode_wins", 0);
        pulse(0, 1, 59);
        push_frame("min_wrap", 0, 24'h010000, 6'b001010, 1'b0);
        drain("min_wrap", 0);

        // Ticks ignored in SET_SEC; tick plus mode in RUN applies the tick
        pulse(1, 0, 1);
        ena = 1'b1;
        repeat (8) @(negedge clk);
        ena = 1'b0;
        push_frame("set_hold", 0, 24'h010000, 6'b001010, 1'b0);
        drain("set_hold", 0);
        pulse(1, 0, 1);
        ena = 1'b1;
        repeat (3) @(negedge clk);
        mode_pulse = 1'b1;
        @(negedge clk);
        mode_pulse = 1'b0;
        ena = 1'b0;
        pulse(0, 1, 1);
        push_frame("tick_mode", 0, 24'h020001, 6'b001010, 1'b0);
        drain("tick_mode", 0);

        // inc ignored in RUN
        pulse(1, 0, 3);
        pulse(0, 1, 1);
        push_frame("run_inc", 0, 24'h020001, 6'b001010, 1'b0);
        drain("run_inc", 0);

        // Display while editing minutes with the prescaler running
        pulse(1, 0, 2);
        ena = 1'b1;
`ifdef RTC_SET_BLINK_EN
        begin
            int p, pb;
            logic [2:0] ps;
            p  = 0;
            ps = bus6.sel_num;
            repeat (24) begin
                @(negedge clk);
                pb = p;
                p  = (p + 1) % 4;
                if (bus6.sel_num != ps) begin
                    if ((bus6.sel_num == 3'd2) || (bus6.sel_num == 3'd3))
                        check_eq("blink_min", 32'(bus6.seg), (pb >= 2) ? 32'd0 : 32'(7'b1111110));
                    else if (bus6.sel_num <= 3'd1)
                        check_eq("blink_hr", 32'(bus6.seg == 7'd0), 32'd0);
                end
                ps = bus6.sel_num;
            end
        end
`else
        push_frame("no_blink", 0, 24'h020001, 6'b001010, 1'b0);
        drain("no_blink", 0);
`endif
        ena = 1'b0;
    endtask

    task automatic main4();
        logic [2:0] prev;
        int w, exp_s;
        prev = bus4.sel_num;
        for (int k = 0; k < 20; k++) begin
            w = 0;
            while ((bus4.sel_num == prev) && (w < 8)) begin
                @(negedge clk);
                w++;
            end
            exp_s = (int'(prev) + 1) % 4;
            check_eq("scan4_seq", 32'(bus4.sel_num), 32'(exp_s));
            prev = bus4.sel_num;
        end
        // SET_HR, hour 01, SET_MIN, then straight back to RUN
        pulse4(1, 0);
        pulse4(0, 1);
        pulse4(1, 0);
        pulse4(1, 0);
        ena4 = 1'b1;
        repeat (240) @(negedge clk);
        ena4 = 1'b0;
        push_frame("d4_run", 1, 24'h010100, 6'b001010, 1'b0);
        drain("d4_run", 1);
    endtask

    initial begin
        rst = 1'b1;
        ena = 1'b0; fmt_12h = 1'b0; mode_pulse = 1'b0; inc_pulse = 1'b0;
        ena4 = 1'b0; fmt4 = 1'b0; mode4 = 1'b0; inc4 = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_sel",     32'(bus6.sel_num),  32'd0);
        check_eq("rst_seg",     32'(bus6.seg),      32'd0);
        check_eq("rst_dp",      32'(bus6.dp),       32'd0);
        check_eq("rst_pm",      32'(bus6.pm),       32'd0);
        check_eq("rst_tick",    32'(bus6.sec_tick), 32'd0);
        check_eq("rst_led_ena", 32'(bus6.led_ena),  32'd1);
        rst = 1'b0;
        fork
            main6();
            main4();
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
